fpu_mul_arbiter: RTL
====================

Name: fpu_mul_arbiter

Overview:
- Shares one pipelined FPU multiplier (Booth-encoded Wallace-tree FPU_MUL) among NUM_REQ requesters, e.g. the FFT butterfly twiddle multiplies.
- Arbitrates round-robin and issues one operand pair per cycle.
- Tracks each request's owner through a tag pipeline matched to the multiplier latency, then routes each product back to its originator.
- Sits between the butterfly/twiddle controllers and the FPU_MUL instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width (IEEE-754 single)
- MUL_LAT, 3, fixed multiplier latency in cycles from o_mul_valid to i_mul_result valid (>=1)
- ID_W, $clog2(NUM_REQ), owner tag width (derived)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  1 = arbitration allowed; 0 = no new grants, in-flight ops drain
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_a  in  NUM_REQ*DATA_W  packed operand A, requester k at [k*DATA_W +: DATA_W]
- i_req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
- o_req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
- o_mul_valid  out  1  operand pair valid to multiplier
- o_mul_a  out  DATA_W  operand A to multiplier
- o_mul_b  out  DATA_W  operand B to multiplier
- i_mul_result  in  DATA_W  multiplier product, sampled when the tag pipeline marks it valid
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe to owner
- o_rsp_data  out  DATA_W  product, shared bus, qualified by o_rsp_valid
- o_busy  out  1  any operation issued but not yet responded

Behaviour:
- Reset (async assert, sync release): o_mul_valid=0, o_mul_a=o_mul_b=0, o_rsp_valid=0, o_rsp_data=0, round-robin pointer=0, all tag-pipeline valids=0, o_busy=0.
- Reset mid-operation discards all in-flight operations; no response is produced for them.
- Arbitration (combinational):
  - Search starts at pointer p: p, p+1, …, wrapping mod NUM_REQ.
  - First k with i_req_valid[k]=1 gets o_req_ready[k]=1.
  - At most one ready bit high; all ready bits 0 when i_enable=0 or no valid.
  - o_req_ready may depend combinationally on i_req_valid.
  - Requesters must hold valid and operands stable until handshake.
- Pointer update: on a handshake with requester k, p <= (k+1) mod NUM_REQ. With no handshake, p holds.
- Issue (registered):
  - Handshake in cycle T -> o_mul_valid=1 with the granted operands in cycle T+1.
  - No handshake -> o_mul_valid=0 next cycle; o_mul_a/o_mul_b hold their last values.
  - Throughput: one issue per cycle, no bubbles with continuous requests.
- Tag pipeline:
  - MUL_LAT-deep shift register of {valid, owner ID} loaded alongside o_mul_valid.
  - Stage MUL_LAT output aligns with i_mul_result in cycle T+1+MUL_LAT.
- Response (registered):
  - In cycle T+2+MUL_LAT: o_rsp_valid[owner]=1 for exactly one cycle and o_rsp_data=i_mul_result.
  - Total request-to-response latency is MUL_LAT+2, fixed.
  - No response backpressure; requesters must accept.
  - o_rsp_data holds its value when o_rsp_valid=0.
- Ordering: responses return in issue order. Back-to-back responses to different owners occur on consecutive cycles.
- o_busy: OR of o_mul_valid and all tag-pipeline valids and o_rsp_valid.
- i_enable falling: grants stop in the same cycle. In-flight ops complete normally and o_busy falls after the last response. The pointer is unaffected.
- Simultaneous new issue and response retire in the same cycle are independent; both take effect.
- Single requester with continuous valid is granted every cycle. Pointer wrap makes it the only candidate each time.

Test Plan:
- Reset then single request (NUM_REQ=4, MUL_LAT=3): k=2, A=0x40000000, B=0x40400000, model returns 0x40C00000 -> ready[2] at T; o_mul_valid at T+1; o_rsp_valid=4'b0100 and o_rsp_data=0x40C00000 at T+5; o_busy high T+1..T+5.
- All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; o_mul_valid high 8 consecutive cycles; responses to owners in the same order, 5 cycles after each grant.
- Pointer=2 with valid on requesters 0 and 3 -> grant 3 first, then 0 the following cycle; pointer ends at 1.
- i_enable=0 for 4 cycles while requests are pending with 2 ops in flight -> no ready bits; both responses still delivered; o_busy drops after the second response; grants resume when i_enable=1.
- Assert i_rst_n=0 asynchronously with 3 ops in flight -> all outputs 0 immediately, no o_rsp_valid after release, pointer=0.
- Requester 1 alone continuously valid for 6 cycles -> ready[1] every cycle, 6 consecutive responses with correct data per issued pair.

Source files
------------

// File: rtl/fpu_mul_arbiter.sv
// Round-robin front end that shares one pipelined FPU multiplier among NUM_REQ requesters
// and routes each product back to its owner through a latency-matched tag pipeline.
module fpu_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_enable,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic                      o_mul_valid,
   output logic [DATA_W-1:0]         o_mul_a,
   output logic [DATA_W-1:0]         o_mul_b,
   input  logic [DATA_W-1:0]         i_mul_result,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]         o_rsp_data,
   output logic                      o_busy
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_next;
   logic [ID_W-1:0]    idx;
   logic               found;
   int                 sum;
   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;

   logic               vld_p0;
   logic [ID_W-1:0]    id_p0;
   logic [DATA_W-1:0]  mul_a_p0;
   logic [DATA_W-1:0]  mul_b_p0;

   logic [MUL_LAT:1]   tag_vld;
   logic [ID_W-1:0]    tag_id [1:MUL_LAT];

   logic [NUM_REQ-1:0] rsp_valid;
   logic [DATA_W-1:0]  rsp_data;

   // Search from the pointer, wrapping modulo NUM_REQ (which need not be a power of two)
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      sum      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = int'(ptr) + i;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = ID_W'(sum);
         if (i_enable && !found && i_req_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_a = i_req_a[k*DATA_W +: DATA_W];
            sel_b = i_req_b[k*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_next    = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
   assign o_req_ready = grant;

   // Stage p0: issue register feeding the multiplier
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p0   <= 1'b0;
         ptr      <= '0;
         mul_a_p0 <= '0;
         mul_b_p0 <= '0;
      end else begin
         vld_p0 <= |grant;
         if (|grant) begin
            ptr      <= ptr_next;
            mul_a_p0 <= sel_a;
            mul_b_p0 <= sel_b;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (|grant) id_p0 <= grant_id;
   end

   assign o_mul_valid = vld_p0;
   assign o_mul_a     = mul_a_p0;
   assign o_mul_b     = mul_b_p0;

   // Tag pipeline: stage MUL_LAT lines up with the product on i_mul_result
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_vld <= '0;
      end else begin
         tag_vld[1] <= vld_p0;
         for (int s = 2; s <= MUL_LAT; s++) tag_vld[s] <= tag_vld[s-1];
      end
   end

   always_ff @(posedge i_clk) begin
      tag_id[1] <= id_p0;
      for (int s = 2; s <= MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
   end

   // Response stage: one-cycle strobe to the owner, data bus holds between products
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_vld[MUL_LAT] ? (NUM_REQ'(1) << tag_id[MUL_LAT]) : '0;
         if (tag_vld[MUL_LAT]) rsp_data <= i_mul_result;
      end
   end

   assign o_rsp_valid = rsp_valid;
   assign o_rsp_data  = rsp_data;
   assign o_busy      = vld_p0 | (|tag_vld) | (|rsp_valid);

endmodule
